// File: rtl/mcu32x_bus_pkg.sv
// Shared types for the MCU32X data-memory responder.
//   state_e    : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   op_e       : captured operation (read or write)
//   WORD_BYTES : bytes per RAM word
package mcu32x_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mcu32x_sp_ram.sv
// Single-port word RAM: asynchronous read, synchronous write.
// Ports:
//   clk      : write clock, rising edge
//   we_i     : write enable
//   idx_i    : word index, shared by read and write
//   wdata_i  : write data
//   rdata_o  : read data at idx_i (combinational)
module mcu32x_sp_ram #(
    parameter  int unsigned DEPTH_WORDS = 256,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // NOTE: the storage array has no reset; contents survive a reset and
    // clearing it would force it out of RAM macros into flops.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mcu32x_mem_responder.sv
// Bus-side responder for the MCU32X data-memory handshake. Backs a
// word-addressed RAM window at BASE_ADDR with WAIT_STATES extra cycles of
// latency and flags misaligned, out-of-window and read+write requests.
// Ports:
//   clk, reset           : clock (rising edge), asynchronous active-high reset
//   address, write_data  : byte address and store data from the initiator
//   mem_read, mem_write  : request strobes, held until mem_ready
//   read_data            : load data, valid in the ready cycle, then held
//   mem_ready            : one-cycle completion pulse (registered)
//   mem_error            : qualifies mem_ready, access rejected (registered)
module mcu32x_mem_responder
    import mcu32x_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic        mem_ready,
    output logic        mem_error
);

    localparam int unsigned   AW           = $clog2(DEPTH_WORDS);
    localparam int unsigned   CW           = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [31:0]   WINDOW_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);
    localparam logic [CW-1:0] WAIT_LOAD    = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    op_e           op_q, op_d;
    logic          err_q, err_d;
    logic [31:0]   read_data_q, read_data_d;

    logic [31:0]   offset;
    logic          req_err;
    logic [AW-1:0] req_idx;
    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic          resp_rd_ok;

    // The full 32-bit offset is range-checked; an address below BASE_ADDR
    // wraps to a huge offset and is rejected by the same compare.
    assign offset  = address - BASE_ADDR;
    assign req_err = (address[1:0] != 2'b00) || (offset >= WINDOW_BYTES)
                     || (mem_read && mem_write);
    assign req_idx = offset[AW+1:2];

    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        op_d        = op_q;
        err_d       = err_q;
        read_data_d = read_data_q;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d   = req_idx;
                    wdata_d = write_data;
                    op_d    = (mem_write && !mem_read) ? OP_WR : OP_RD;
                    err_d   = req_err;
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                if (resp_rd_ok) begin
                    read_data_d = ram_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            op_q        <= OP_RD;
            err_q       <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            op_q        <= op_d;
            err_q       <= err_d;
            read_data_q <= read_data_d;
        end
    end

    // Outputs decode only flops: nothing combinational from the request pins.
    assign resp_rd_ok = (state_q == RESP) && (op_q == OP_RD) && !err_q;
    assign ram_we     = (state_q == RESP) && (op_q == OP_WR) && !err_q;
    assign mem_ready  = (state_q == RESP);
    assign mem_error  = (state_q == RESP) && err_q;
    // During a good read RESP the RAM word is shown directly; the register
    // captures it at the end of the cycle and holds it afterwards.
    assign read_data  = resp_rd_ok ? ram_rdata : read_data_q;

    mcu32x_sp_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

endmodule

// File: tb/tb_mcu32x_mem_responder.sv
// Self-checking bench for mcu32x_mem_responder: a WAIT_STATES=2 instance
// (index 0) and a WAIT_STATES=0 instance (index 1), both mapped at 0x1000
// with 256 words, compared against an array model of the memory window.
module tb_mcu32x_mem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;
    localparam int          WS    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address, write_data, read_data;
    logic        mem_read, mem_write, mem_ready, mem_error;
    logic [31:0] address0, write_data0, read_data0;
    logic        mem_read0, mem_write0, mem_ready0, mem_error0;

    int checks = 0;
    int passes = 0;

    logic [31:0] ref_mem [2][DEPTH];
    logic [31:0] ref_rd  [2];

    always #5 clk = ~clk;

    mcu32x_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .mem_read(mem_read), .mem_write(mem_write), .read_data(read_data),
        .mem_ready(mem_ready), .mem_error(mem_error)
    );

    mcu32x_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)
    ) dut0 (
        .clk(clk), .reset(reset), .address(address0), .write_data(write_data0),
        .mem_read(mem_read0), .mem_write(mem_write0), .read_data(read_data0),
        .mem_ready(mem_ready0), .mem_error(mem_error0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? mem_ready : mem_ready0;
    endfunction

    function automatic logic errf(input int sel);
        return (sel == 0) ? mem_error : mem_error0;
    endfunction

    function automatic logic [31:0] rdat(input int sel);
        return (sel == 0) ? read_data : read_data0;
    endfunction

    // Legal iff word aligned, inside [BASE, BASE+DEPTH*4) and not read+write.
    function automatic bit exp_err_f(input logic rd, input logic wr, input logic [31:0] a);
        longint unsigned la;
        la = 64'(a);
        return (a % 4 != 0) || (la < 64'(BASE)) || (la >= 64'(BASE) + DEPTH * 4) || (rd && wr);
    endfunction

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            mem_read = rd; mem_write = wr; address = a; write_data = wd;
        end else begin
            mem_read0 = rd; mem_write0 = wr; address0 = a; write_data0 = wd;
        end
    endtask

    // Starts just after a rising edge; request is visible from this cycle (N).
    // mem_ready is expected low in N..N+ws and high in N+1+ws.
    task automatic txn(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd, input bit garble);
        int ws;
        bit err;
        int idx;
        ws  = (sel == 0) ? WS : 0;
        err = exp_err_f(rd, wr, a);
        idx = int'((a - BASE) / 4) % DEPTH;
        drive(sel, rd, wr, a, wd);
        for (int c = 0; c <= ws; c++) begin
            @(negedge clk);
            check("wait_ready", 32'(rdy(sel)), 32'd0);
            check("wait_error", 32'(errf(sel)), 32'd0);
            check("wait_rdata", rdat(sel), ref_rd[sel]);
            @(posedge clk); #1;
            if (garble) drive(sel, 1'($urandom), 1'($urandom), $urandom, $urandom);
        end
        if (!err && rd) ref_rd[sel] = ref_mem[sel][idx];
        @(negedge clk);
        check("ready", 32'(rdy(sel)), 32'd1);
        check("error", 32'(errf(sel)), 32'(err));
        check("rdata", rdat(sel), ref_rd[sel]);
        @(posedge clk); #1;
        if (!err && wr) ref_mem[sel][idx] = wd;
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(mem_ready), 32'd0);
            check("idle_rdata", read_data, ref_rd[0]);
            @(posedge clk); #1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 6) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (k == 7) return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        if (k == 8) return ($urandom_range(0, 1) == 0) ? BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 63))
                                                       : BASE - 32'(4 * $urandom_range(1, 64));
        return $urandom;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        ref_rd[0] = 32'd0;
        ref_rd[1] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  32'(mem_ready), 32'd0);
        check("rst_error",  32'(mem_error), 32'd0);
        check("rst_rdata",  read_data, 32'd0);
        check("rst_ready0", 32'(mem_ready0), 32'd0);
        check("rst_rdata0", read_data0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Zero-wait-state build: ready in N+1, including errors.
        txn(1, 1'b0, 1'b1, 32'h0000_13FC, 32'hA5A5_A5A5, 1'b0);
        txn(1, 1'b1, 1'b0, 32'h0000_13FC, 32'd0, 1'b0);
        txn(1, 1'b1, 1'b0, 32'h0000_1002, 32'd0, 1'b0);
        txn(1, 1'b0, 1'b1, 32'h0000_1000, 32'h0BAD_F00D, 1'b0);
        txn(1, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 1'b0);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) txn(0, 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 1'b0);

        // Write then read back, value held while idle.
        txn(0, 1'b0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_1004, 32'd0, 1'b0);
        idle(3);

        // Misaligned, above window, below window.
        txn(0, 1'b1, 1'b0, 32'h0000_1002, 32'd0, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_1400, 32'd0, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_0FFC, 32'd0, 1'b0);

        // Read and write together is rejected, memory keeps its value.
        txn(0, 1'b1, 1'b1, 32'h0000_1008, 32'h0000_1234, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_1008, 32'd0, 1'b0);

        // Last word of the window.
        txn(0, 1'b0, 1'b1, 32'h0000_13FC, 32'hA5A5_A5A5, 1'b0);
        txn(0, 1'b1, 1'b0, 32'h0000_13FC, 32'd0, 1'b0);

        // Back-to-back writes then reads.
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 1'b1, 32'h0000_1020 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) txn(0, 1'b1, 1'b0, 32'h0000_1020 + 32'(4 * i), 32'd0, 1'b0);

        // Reset during WAIT aborts the write.
        drive(0, 1'b0, 1'b1, 32'h0000_1010, 32'h0000_0055);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("abort_ready",  32'(mem_ready), 32'd0);
        check("abort_error",  32'(mem_error), 32'd0);
        check("abort_rdata",  read_data, 32'd0);
        check("abort_rdata0", read_data0, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ref_rd[0] = 32'd0;
        ref_rd[1] = 32'd0;
        idle(4);
        txn(0, 1'b1, 1'b0, 32'h0000_1010, 32'd0, 1'b0);

        // Random traffic, with requests sometimes disturbed mid-transaction.
        for (int t = 0; t < 300; t++) begin
            int  k;
            logic rd, wr;
            k  = $urandom_range(0, 9);
            rd = (k <= 4) || (k == 9);
            wr = (k >= 5);
            txn(0, rd, wr, rand_addr(), $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        @(negedge clk);
        check("final_ready", 32'(mem_ready), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
